// File: rtl/i2s_frame_pack.sv
// i2s_frame_pack: pairs left/right words from an I2S receiver into stereo
// frames, buffers them in a first-word-fall-through FIFO with a valid/ready
// interface to the mixer, and keeps sticky channel-order and overflow flags.

module i2s_frame_pack #(
    parameter int BITS_PRECISION = 24,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              sck,
    input  logic                              rst,
    input  logic [BITS_PRECISION-1:0]         data_in,
    input  logic                              left_rightn,
    input  logic                              data_en,
    output logic [BITS_PRECISION-1:0]         frame_left,
    output logic [BITS_PRECISION-1:0]         frame_right,
    output logic                              frame_valid,
    input  logic                              frame_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow,
    output logic                              sync_err,
    input  logic                              clear_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        WAIT_LEFT = 1'b0,
        HAVE_LEFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [BITS_PRECISION-1:0] left;
        logic [BITS_PRECISION-1:0] right;
    } frame_t;

    state_t                    state_q, state_d;
    logic [BITS_PRECISION-1:0] hold_q, hold_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]          level_q, level_d;
    logic                      overflow_q, overflow_d;
    logic                      sync_err_q, sync_err_d;
    frame_t                    mem_q [FIFO_DEPTH];

    logic   push_req;
    logic   push;
    logic   pop;
    logic   full;
    logic   order_err;
    logic   drop;
    frame_t head;

    // Next-state logic for the pairing FSM, FIFO bookkeeping and sticky flags.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        state_d    = state_q;
        hold_d     = hold_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        push_req   = 1'b0;
        order_err  = 1'b0;

        full = (level_q == LVL_W'(FIFO_DEPTH));
        pop  = (level_q != '0) && frame_ready;

        if (data_en) begin
            unique case (state_q)
                WAIT_LEFT: begin
                    if (left_rightn) begin
                        hold_d  = data_in;
                        state_d = HAVE_LEFT;
                    end else begin
                        order_err = 1'b1;
                    end
                end
                HAVE_LEFT: begin
                    if (left_rightn) begin
                        hold_d    = data_in;
                        order_err = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        state_d  = WAIT_LEFT;
                    end
                end
                default: state_d = WAIT_LEFT;
            endcase
        end

        // A full FIFO still accepts a push when the head leaves on the same edge.
        push = push_req && (!full || pop);
        drop = push_req && full && !pop;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Set events take priority over a coincident clear.
        overflow_d = drop      || (overflow_q && !clear_err);
        sync_err_d = order_err || (sync_err_q && !clear_err);
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge sck) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= WAIT_LEFT;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Frame storage; written at the tail whenever a frame is accepted.
    always_ff @(posedge sck) begin
        // NOTE: storage is deliberately not reset; an empty FIFO masks it at the outputs, so stale entries are never seen.
        if (rst && push) begin
            mem_q[wr_ptr_q] <= '{left: hold_q, right: data_in};
        end
    end

    // Head of the FIFO is presented directly; outputs read zero when empty.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        frame_valid = (level_q != '0);
        frame_left  = frame_valid ? head.left  : '0;
        frame_right = frame_valid ? head.right : '0;
    end

    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign sync_err   = sync_err_q;

endmodule
